// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_e;

    localparam int TO_CYCLES_DEF = 255;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/wb_arb_timeout.sv
// Watchdog for a stalled Wishbone transfer: raises a one-cycle expire pulse
// after TO_CYCLES consecutive stalled cycles without an intervening clear.
module wb_arb_timeout
    import wb_arb_pkg::*;
#(
    parameter int TO_CYCLES = TO_CYCLES_DEF,
    parameter int TO_WIDTH  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic stall,
    output logic expire
);

    localparam logic [TO_WIDTH-1:0] LIMIT = TO_WIDTH'(TO_CYCLES - 1);

    logic [TO_WIDTH-1:0] cnt_q, cnt_d;
    logic                expire_q, expire_d;

    // Clear wins over stall so a grant change never leaks an error to the new owner.
    always_comb begin
        cnt_d    = cnt_q;
        expire_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (stall) begin
            if (cnt_q == LIMIT) begin
                cnt_d    = '0;
                expire_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            expire_q <= expire_d;
        end
    end

    assign expire = expire_q;

endmodule

// File: rtl/wb_arbiter2.sv
// Round-robin two-master Wishbone arbiter; the grant is held for a whole bus cycle.
// Define WB_ARB_TIMEOUT_EN to build the stalled-cycle watchdog (m0_err/m1_err).
module wb_arbiter2
    import wb_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int TO_CYCLES  = TO_CYCLES_DEF,
    parameter int TO_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_cycle,
    input  logic                  m0_strobe,
    input  logic                  m0_write,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wrData,
    output logic                  m0_ack,
    output logic                  m0_err,
    output logic [DATA_WIDTH-1:0] m0_rdData,

    input  logic                  m1_cycle,
    input  logic                  m1_strobe,
    input  logic                  m1_write,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wrData,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic [DATA_WIDTH-1:0] m1_rdData,

    output logic                  glob_cycle,
    output logic                  glob_strobe,
    output logic                  glob_write,
    output logic [ADDR_WIDTH-1:0] glob_addr,
    output logic [DATA_WIDTH-1:0] glob_wrData,
    input  logic                  glob_ack,
    input  logic [DATA_WIDTH-1:0] glob_rdData,

    output logic [1:0]            gnt
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (m0_cycle && m1_cycle) begin
                    state_d = (last_q == M1) ? ARB_GNT0 : ARB_GNT1;
                end else if (m0_cycle) begin
                    state_d = ARB_GNT0;
                end else if (m1_cycle) begin
                    state_d = ARB_GNT1;
                end
            end
            // A released grant hands straight over to a waiting master.
            ARB_GNT0: if (!m0_cycle) state_d = m1_cycle ? ARB_GNT1 : ARB_IDLE;
            ARB_GNT1: if (!m1_cycle) state_d = m0_cycle ? ARB_GNT0 : ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
        if (state_d == ARB_GNT0) last_d = M0;
        else if (state_d == ARB_GNT1) last_d = M1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            last_q  <= M1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        glob_cycle  = 1'b0;
        glob_strobe = 1'b0;
        glob_write  = 1'b0;
        glob_addr   = '0;
        glob_wrData = '0;
        unique case (state_q)
            ARB_GNT0: begin
                glob_cycle  = m0_cycle;
                glob_strobe = m0_strobe;
                glob_write  = m0_write;
                glob_addr   = m0_addr;
                glob_wrData = m0_wrData;
            end
            ARB_GNT1: begin
                glob_cycle  = m1_cycle;
                glob_strobe = m1_strobe;
                glob_write  = m1_write;
                glob_addr   = m1_addr;
                glob_wrData = m1_wrData;
            end
            default: ;
        endcase
    end

    assign m0_ack    = glob_ack & (state_q == ARB_GNT0);
    assign m1_ack    = glob_ack & (state_q == ARB_GNT1);
    assign m0_rdData = glob_rdData;
    assign m1_rdData = glob_rdData;
    assign gnt       = {state_q == ARB_GNT1, state_q == ARB_GNT0};

`ifdef WB_ARB_TIMEOUT_EN
    logic to_stall, to_clear, to_expire;

    assign to_stall = glob_cycle & glob_strobe & ~glob_ack;
    assign to_clear = ~glob_strobe | glob_ack | (state_d != state_q);

    wb_arb_timeout #(
        .TO_CYCLES (TO_CYCLES),
        .TO_WIDTH  (TO_WIDTH)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (to_clear),
        .stall  (to_stall),
        .expire (to_expire)
    );

    assign m0_err = to_expire & (state_q == ARB_GNT0);
    assign m1_err = to_expire & (state_q == ARB_GNT1);
`else
    assign m0_err = 1'b0;
    assign m1_err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: directed scenarios plus random traffic, scored against
// a per-cycle ownership model of the round-robin rules.
module tb_wb_arbiter2;

    localparam int TO = 8;

    typedef struct packed {
        logic        c, s, w;
        logic [15:0] a, d;
    } mreq_t;

    typedef struct packed {
        logic [1:0]  gnt;
        logic        gc, gs, gw;
        logic [15:0] ga, gd;
        logic        a0, a1, e0, e1;
        logic [15:0] r0, r1;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    mreq_t       m0r, m1r;
    logic        glob_ack;
    logic [15:0] glob_rdData;

    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [15:0] m0_rdData, m1_rdData;
    logic        glob_cycle, glob_strobe, glob_write;
    logic [15:0] glob_addr, glob_wrData;
    logic [1:0]  gnt;

    wb_arbiter2 #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (16),
        .TO_CYCLES  (TO),
        .TO_WIDTH   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m0_cycle    (m0r.c),
        .m0_strobe   (m0r.s),
        .m0_write    (m0r.w),
        .m0_addr     (m0r.a),
        .m0_wrData   (m0r.d),
        .m0_ack      (m0_ack),
        .m0_err      (m0_err),
        .m0_rdData   (m0_rdData),
        .m1_cycle    (m1r.c),
        .m1_strobe   (m1r.s),
        .m1_write    (m1r.w),
        .m1_addr     (m1r.a),
        .m1_wrData   (m1r.d),
        .m1_ack      (m1_ack),
        .m1_err      (m1_err),
        .m1_rdData   (m1_rdData),
        .glob_cycle  (glob_cycle),
        .glob_strobe (glob_strobe),
        .glob_write  (glob_write),
        .glob_addr   (glob_addr),
        .glob_wrData (glob_wrData),
        .glob_ack    (glob_ack),
        .glob_rdData (glob_rdData),
        .gnt         (gnt)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    obs_t exp_q[$];

    // Reference: who owns the bus after each edge, who was granted last, and
    // how many consecutive stalled cycles the current owner has accumulated.
    int owner  = -1;
    int last   = 1;
    int run    = 0;
    int err_to = -1;

    function automatic mreq_t mr(logic c, logic s, logic w, logic [15:0] a, logic [15:0] d);
        mreq_t r;
        r.c = c; r.s = s; r.w = w; r.a = a; r.d = d;
        return r;
    endfunction

    function automatic mreq_t req_of(int i);
        return (i == 0) ? m0r : m1r;
    endfunction

    task automatic model_reset();
        owner = -1; last = 1; run = 0; err_to = -1;
    endtask

    task automatic model_edge();
        logic [1:0] req;
        int         nxt;
        req = {m1r.c, m0r.c};
        if (owner >= 0 && req[owner]) nxt = owner;
        else if (req == 2'b11)        nxt = 1 - last;
        else if (req[0])              nxt = 0;
        else if (req[1])              nxt = 1;
        else                          nxt = -1;
        err_to = -1;
`ifdef WB_ARB_TIMEOUT_EN
        begin
            mreq_t cur;
            logic  stalled;
            stalled = 1'b0;
            if (owner >= 0) begin
                cur     = req_of(owner);
                stalled = cur.c && cur.s && !glob_ack;
            end
            if (stalled && nxt == owner) begin
                run++;
                if (run == TO) begin
                    err_to = owner;
                    run    = 0;
                end
            end else begin
                run = 0;
            end
        end
`endif
        if (nxt >= 0) last = nxt;
        owner = nxt;
    endtask

    function automatic obs_t expect_now();
        obs_t  o;
        mreq_t cur;
        o    = '0;
        o.r0 = glob_rdData;
        o.r1 = glob_rdData;
        if (owner >= 0) begin
            cur   = req_of(owner);
            o.gnt = (owner == 0) ? 2'b01 : 2'b10;
            o.gc  = cur.c;
            o.gs  = cur.s;
            o.gw  = cur.w;
            o.ga  = cur.a;
            o.gd  = cur.d;
            o.a0  = glob_ack && owner == 0;
            o.a1  = glob_ack && owner == 1;
        end
        o.e0 = (err_to == 0);
        o.e1 = (err_to == 1);
        return o;
    endfunction

    function automatic obs_t actual();
        obs_t o;
        o.gnt = gnt;
        o.gc  = glob_cycle;  o.gs = glob_strobe; o.gw = glob_write;
        o.ga  = glob_addr;   o.gd = glob_wrData;
        o.a0  = m0_ack;      o.a1 = m1_ack;
        o.e0  = m0_err;      o.e1 = m1_err;
        o.r0  = m0_rdData;   o.r1 = m1_rdData;
        return o;
    endfunction

    // One clock of stimulus: advance the model over the edge, apply new inputs,
    // then queue what the outputs must show for the rest of this cycle.
    task automatic step(mreq_t r0, mreq_t r1, logic ack, logic [15:0] rd);
        @(posedge clk);
        #1;
        model_edge();
        m0r         = r0;
        m1r         = r1;
        glob_ack    = ack;
        glob_rdData = rd;
        exp_q.push_back(expect_now());
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, req);
        end
    endtask

    obs_t mon_e, mon_a;
    always @(negedge clk) begin
        if (rst && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = actual();
            checks++;
            if (mon_a !== mon_e) begin
                failures++;
                $display("FAIL scoreboard t=%0t actual=%h expected=%h", $time, mon_a, mon_e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout t=%0t", $time);
        $fatal(1, "simulation time limit");
    end

    initial begin
        mreq_t idle, n0, n1;
        int    errk;
        idle        = '0;
        m0r         = '0;
        m1r         = '0;
        glob_ack    = 1'b1;
        glob_rdData = 16'h0;

        // Reset state, with a stray ack that must not reach either master.
        repeat (2) @(posedge clk);
        #2;
        chk("reset_outputs", 64'({gnt, glob_cycle, glob_strobe, glob_write, glob_addr,
                                  glob_wrData, m0_ack, m1_ack, m0_err, m1_err}), 64'h0);
        glob_ack = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        // Tie straight after reset goes to m0, then hands over without a gap.
        step(mr(1,0,0,0,0), mr(1,0,0,0,0), 0, 0);
        step(mr(1,0,0,0,0), mr(1,0,0,0,0), 0, 0);
        at_neg(); chk("tie_first_gnt", 64'(gnt), 64'h1);
        step(idle, mr(1,0,0,0,0), 0, 0);
        step(idle, mr(1,0,0,0,0), 0, 0);
        at_neg(); chk("handover_gnt", 64'(gnt), 64'h2);
        step(idle, idle, 0, 0);
        step(idle, idle, 0, 0);
        step(mr(1,0,0,0,0), mr(1,0,0,0,0), 0, 0);
        step(mr(1,0,0,0,0), mr(1,0,0,0,0), 0, 0);
        at_neg(); chk("tie_second_gnt", 64'(gnt), 64'h1);
        step(idle, mr(1,0,0,0,0), 0, 0);
        step(idle, idle, 0, 0);
        step(idle, idle, 0, 0);

        // Single master write, acked two cycles after strobe.
        step(mr(1,1,1,16'h0105,16'hBEEF), idle, 0, 0);
        step(mr(1,1,1,16'h0105,16'hBEEF), idle, 0, 0);
        at_neg(); chk("single_addr_data", 64'({glob_addr, glob_wrData}), 64'h0105_BEEF);
        step(mr(1,1,1,16'h0105,16'hBEEF), idle, 0, 0);
        step(mr(1,1,1,16'h0105,16'hBEEF), idle, 1, 0);
        at_neg(); chk("single_ack", 64'({m0_ack, m1_ack}), 64'h2);
        step(idle, idle, 0, 0);
        step(idle, idle, 0, 0);

        // Locked cycle: m1 keeps the bus across three reads while m0 waits.
        step(idle, mr(1,1,0,16'h0010,0), 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(mr(1,0,0,0,0), mr(1,1,0,16'(16'h0010 + k),0), 0, 0);
            step(mr(1,0,0,0,0), mr(1,1,0,16'(16'h0010 + k),0), 1, 16'(16'hA5A0 + k));
            at_neg();
            chk("locked_rd", 64'(m1_rdData), 64'(16'hA5A0 + k));
            chk("locked_gnt", 64'(gnt), 64'h2);
        end
        step(mr(1,0,0,0,0), idle, 0, 0);
        step(mr(1,0,0,0,0), idle, 0, 0);
        at_neg(); chk("locked_release_gnt", 64'(gnt), 64'h1);
        step(idle, idle, 0, 0);
        step(idle, idle, 0, 0);

        // Stalled slave with m1 pending.
        step(mr(1,1,0,16'h0030,0), idle, 0, 0);
        step(mr(1,1,0,16'h0030,0), mr(1,0,0,0,0), 0, 0);
        errk = 0;
        for (int k = 1; k <= 20; k++) begin
            step(mr(1,1,0,16'h0030,0), mr(1,0,0,0,0), 0, 0);
            at_neg();
            if (m0_err) begin
                errk = k;
                break;
            end
        end
`ifdef WB_ARB_TIMEOUT_EN
        chk("timeout_latency", 64'(errk), 64'(TO));
`else
        chk("no_timeout", 64'(errk), 64'h0);
`endif
        step(idle, mr(1,0,0,0,0), 0, 0);
        step(idle, mr(1,0,0,0,0), 0, 0);
        at_neg(); chk("after_stall_gnt", 64'(gnt), 64'h2);
        step(idle, idle, 0, 0);

        // Reset while m1 is mid-transfer.
        step(idle, mr(1,1,0,16'h0020,0), 0, 0);
        step(idle, mr(1,1,0,16'h0020,0), 0, 0);
        at_neg(); chk("pre_reset_gnt", 64'(gnt), 64'h2);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_async", 64'({gnt, glob_cycle, glob_strobe, glob_addr}), 64'h0);
        m0r = '0;
        m1r = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        step(idle, idle, 0, 0);
        step(idle, idle, 0, 0);
        at_neg(); chk("post_reset_gnt", 64'(gnt), 64'h0);

        // Random traffic: masters hold cycles for a while, slave acks at random.
        for (int i = 0; i < 1500; i++) begin
            n0 = m0r;
            n1 = m1r;
            if (n0.c) begin
                if ($urandom_range(3) == 0) n0 = '0;
                else n0 = mr(1'b1, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
            end else if ($urandom_range(2) == 0) begin
                n0 = mr(1'b1, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
            end
            if (n1.c) begin
                if ($urandom_range(3) == 0) n1 = '0;
                else n1 = mr(1'b1, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
            end else if ($urandom_range(2) == 0) begin
                n1 = mr(1'b1, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
            end
            step(n0, n1, 1'($urandom), 16'($urandom));
        end
        step(idle, idle, 0, 0);
        step(idle, idle, 0, 0);
        at_neg();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
